// File: rtl/solenoid_pkg.sv
// Shared definitions for the solenoid driver: channel count, channel
// indices and the sequencing FSM state type.
package solenoid_pkg;

  localparam int NUM_CH      = 3;
  localparam int CH_DISPENSE = 0;
  localparam int CH_COIN     = 1;
  localparam int CH_CHANGE   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/prio_pick3.sv
// Fixed-priority selector: returns a one-hot vector for the lowest-index
// set request bit (dispense > coin return > change release), or zero.
module prio_pick3
  import solenoid_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] pick
);

  // Lowest-index request wins.
  always_comb begin
    pick = 3'b000;
    if (req[CH_DISPENSE]) begin
      pick[CH_DISPENSE] = 1'b1;
    end else if (req[CH_COIN]) begin
      pick[CH_COIN] = 1'b1;
    end else if (req[CH_CHANGE]) begin
      pick[CH_CHANGE] = 1'b1;
    end else begin
      pick = 3'b000;
    end
  end

endmodule

// File: rtl/solenoid_act_chk.sv
// Property checker: the solenoid drive vector is never multi-hot.
module solenoid_act_chk (
  input logic       clk,
  input logic       reset,
  input logic [2:0] act
);

  // At most one solenoid may be energised at any clock edge.
  act_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(act))
    else $error("act multi-hot: %b", act);

endmodule

// File: rtl/solenoid_driver.sv
// Solenoid pulse sequencer: queues one request per channel, fires one
// fixed-length pulse at a time in priority order, and enforces an all-off
// gap plus one idle cycle between pulses.
// Optional feature: define SOLENOID_DRIVER_OVF_EN to add the sticky ovf
// output that flags any request dropped because its channel was already queued.
module solenoid_driver
  import solenoid_pkg::*;
#(
  parameter int PULSE_CYCLES = 8,
  parameter int GAP_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] cmd,
`ifdef SOLENOID_DRIVER_OVF_EN
  output logic              ovf,
`endif
  output logic [NUM_CH-1:0] act,
  output logic              busy,
  output logic [NUM_CH-1:0] pending
);

  // Counters hold "cycles remaining minus one" so they never need to wrap.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit         HAS_GAP    = (GAP_CYCLES > 0);

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;
  logic [7:0]        cnt_next;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pick;
  logic [NUM_CH-1:0] act_next;
  logic [NUM_CH-1:0] pending_next;
  logic              busy_next;

  assign req = pending | cmd;

  prio_pick3 u_pick (
    .req  (req),
    .pick (pick)
  );

  // Next-state, counter, drive and queue logic.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    act_next     = act;
    pending_next = req;
    case (state)
      ST_IDLE: begin
        if (pick != 3'b000) begin
          state_next   = ST_PULSE;
          cnt_next     = PULSE_LOAD;
          act_next     = pick;
          pending_next = req & ~pick;
        end else begin
          act_next     = 3'b000;
        end
      end
      ST_PULSE: begin
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else begin
          act_next = 3'b000;
          if (HAS_GAP) begin
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
          end
        end
      end
      ST_GAP: begin
        act_next = 3'b000;
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
        act_next   = 3'b000;
      end
    endcase
    busy_next = (state_next != ST_IDLE) || (pending_next != 3'b000);
  end

  // State, counter and registered outputs; reset discards everything incl. cmd.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      act     <= 3'b000;
      pending <= 3'b000;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      act     <= act_next;
      pending <= pending_next;
      busy    <= busy_next;
    end
  end

`ifdef SOLENOID_DRIVER_OVF_EN
  logic dropped;
  assign dropped = |(cmd & pending);

  // Sticky overflow: a request arrived for a channel already queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf | dropped;
    end
  end
`endif

endmodule

// File: doc/solenoid_driver.md
SOLENOID_DRIVER -- requirements
Module: solenoid_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 8, actuator on-time in clk cycles (legal 1..255).
REQ-002 Parameter GAP_CYCLES, default 4, mandatory all-off time between consecutive pulses (legal 0..255).
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd  input  3  one-cycle command strobes: bit0 dispense, bit1 coin return, bit2 change release.
REQ-006 act  output  3  registered solenoid drive, at most one bit high at any time.
REQ-007 busy  output  1  high whenever state is not IDLE or any request is pending.
REQ-008 pending  output  3  requests accepted but not yet started.

Function
REQ-009 Each cmd bit sampled high at a rising edge SHALL set the corresponding pending bit at that edge.
REQ-010 The FSM SHALL have states IDLE, PULSE and GAP.
REQ-011 In IDLE, if (pending | cmd) is non-zero at an edge, the FSM SHALL enter PULSE for the lowest-index set bit, clear that pending bit, and drive act one-hot for that channel starting at that edge (1-cycle latency from the cmd edge).
REQ-012 PULSE SHALL hold act for exactly PULSE_CYCLES cycles.
REQ-013 After PULSE, the FSM SHALL enter GAP with act = 0 for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-014 If GAP_CYCLES = 0, PULSE SHALL go to IDLE directly and produce no gap cycle.
REQ-015 IDLE lasts at least one cycle between pulses, so pulses are separated by GAP_CYCLES + 1 cycles of all-off minimum.
REQ-016 Arbitration is fixed priority: bit0 > bit1 > bit2, evaluated only in IDLE, never preempting a running pulse.
REQ-017 A cmd bit arriving while its pending bit is already set SHALL be dropped; at most one request per channel is queued.
REQ-018 A cmd bit for the channel currently pulsing SHALL queue a new request, which is serviced after the current gap.
REQ-019 Simultaneous cmd bits SHALL all be queued and serviced in priority order.
REQ-020 The cycle counter SHALL be 8 bits wide and SHALL never wrap; it reloads on each state entry.

Reset
REQ-021 reset high at a clock edge SHALL force state IDLE, act = 0, pending = 0, busy = 0, and counter = 0, overriding cmd.
REQ-022 reset asserted mid-pulse SHALL drop act to 0 at that edge and discard all queued requests.
REQ-023 cmd sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-024 Macro SOLENOID_DRIVER_OVF_EN: when defined, the block SHALL add output ovf (1 bit), a sticky flag set on any dropped request per REQ-017 and cleared only by reset.
REQ-025 When SOLENOID_DRIVER_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package solenoid_pkg SHALL hold the channel count constant (3), the channel index constants, and the FSM state typedef.
REQ-027 One sub-module, prio_pick3, SHALL implement the combinational lowest-index one-hot selector; all other logic SHALL be in solenoid_driver.

Verification (PULSE_CYCLES = 8, GAP_CYCLES = 4 unless stated)
REQ-028 Test single command: cmd = 001 at edge 0 -> act = 001 for edges 0..7, act = 000 for 8..11, busy = 0 from edge 12.
REQ-029 Test simultaneous commands: cmd = 111 once -> pulses occur in order 001, 010, 100, each 8 cycles, with at least 5 all-off cycles between them, and pending = 110 after the first pulse starts.
REQ-030 Test overflow: cmd = 010 during the bit1 pulse, then again 2 cycles later -> exactly one further bit1 pulse occurs; with SOLENOID_DRIVER_OVF_EN, ovf = 1 from the second drop onward.
REQ-031 Test reset mid-pulse: reset at pulse cycle 3 with pending = 100 -> act, pending and busy are 0 at that edge, and no later pulse occurs.
REQ-032 Test zero gap: with GAP_CYCLES = 0 and cmd = 011 -> bit0 pulse, exactly 1 idle cycle, then the bit1 pulse.
REQ-033 A checker SHALL assert throughout all tests that act is never multi-hot.
